// File: rtl/m_ext_pkg.sv
// Shared encodings for the M-extension multiply/divide unit: funct3 selects,
// control states and the default datapath width.
package m_ext_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [2:0] {
    F3Mul    = 3'b000,
    F3Mulh   = 3'b001,
    F3Mulhsu = 3'b010,
    F3Mulhu  = 3'b011,
    F3Div    = 3'b100,
    F3Divu   = 3'b101,
    F3Rem    = 3'b110,
    F3Remu   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/m_ext_unit.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide
// sharing one WIDTH+1 adder, with sign conditioning and divide fast paths.
module m_ext_unit
  import m_ext_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             ip_clk,
  input  logic             ip_rst_n,
  input  logic             ip_start,
  input  logic             ip_flush,
  input  logic [2:0]       ip_funct_3,
  input  logic [WIDTH-1:0] ip_rs1_data,
  input  logic [WIDTH-1:0] ip_rs2_data,
  output logic             op_busy,
  output logic             op_done,
  output logic [WIDTH-1:0] op_result
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

  state_e             state_q, state_d;
  funct3_e            funct3_q, funct3_d, f3_in;
  logic [WIDTH-1:0]   opnd_q, opnd_d, res_q, res_d, res_fix;
  // MUL: {product high, multiplier/product low}; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d, fast_q, fast_d;

  assign f3_in = funct3_e'(ip_funct_3);

  logic             neg_a, neg_b, div_zero, div_ovf;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    neg_a    = ip_rs1_data[WIDTH-1] && (f3_in inside {F3Mulh, F3Mulhsu, F3Div, F3Rem});
    neg_b    = ip_rs2_data[WIDTH-1] && (f3_in inside {F3Mulh, F3Div, F3Rem});
    mag_a    = neg_a ? -ip_rs1_data : ip_rs1_data;
    mag_b    = neg_b ? -ip_rs2_data : ip_rs2_data;
    div_zero = (ip_rs2_data == '0);
    div_ovf  = (f3_in inside {F3Div, F3Rem}) && (ip_rs1_data == MinNeg) && (ip_rs2_data == '1);
  end

  // Shared adder: adds the multiplicand in MUL, subtracts the divisor in DIV.
  logic [WIDTH:0] add_x, add_y, add_sum;
  logic           add_sub;

  always_comb begin
    add_sub = (state_q == StDiv);
    if (add_sub) begin
      add_x = acc_q[2*WIDTH-1:WIDTH-1];
      add_y = ~{1'b0, opnd_q};
    end else begin
      add_x = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_y = {1'b0, opnd_q};
    end
    add_sum = add_x + add_y + {{WIDTH{1'b0}}, add_sub};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_src, rem_fix;

  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // On the fast path the untouched dividend magnitude still sits in the low half.
    rem_src  = fast_q ? acc_q[WIDTH-1:0] : acc_q[2*WIDTH-1:WIDTH];
    rem_fix  = sign_a_q ? -rem_src : rem_src;
    if (fast_q) begin
      if (opnd_q == '0) begin
        quo_fix = '1;
      end else begin
        quo_fix = MinNeg;
        rem_fix = '0;
      end
    end
    case (funct3_q)
      F3Mul:                     res_fix = prod_fix[WIDTH-1:0];
      F3Mulh, F3Mulhsu, F3Mulhu: res_fix = prod_fix[2*WIDTH-1:WIDTH];
      F3Div, F3Divu:             res_fix = quo_fix;
      default:                   res_fix = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    fast_d   = fast_q;
    res_d    = res_q;

    unique case (state_q)
      StIdle: begin
        if (ip_start && !ip_flush) begin
          funct3_d = f3_in;
          sign_a_d = neg_a;
          sign_b_d = neg_b;
          cnt_d    = '0;
          fast_d   = ip_funct_3[2] && (div_zero || div_ovf);
          opnd_d   = ip_funct_3[2] ? mag_b : mag_a;
          acc_d    = {{WIDTH{1'b0}}, (ip_funct_3[2] ? mag_a : mag_b)};
          state_d  = ip_funct_3[2] ? StDiv : StMul;
        end
      end
      StMul: begin
        if (cnt_q == LastCnt) begin
          res_d   = res_fix;
          state_d = StDone;
        end else begin
          acc_d = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDiv: begin
        if (fast_q || (cnt_q == LastCnt)) begin
          res_d   = res_fix;
          state_d = StDone;
        end else begin
          acc_d = add_sum[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (ip_flush) begin
      state_d = StIdle;
      res_d   = res_q;
    end
  end

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      state_q  <= StIdle;
      funct3_q <= F3Mul;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      fast_q   <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      fast_q   <= fast_d;
      res_q    <= res_d;
    end
  end

  assign op_busy   = (state_q != StIdle);
  assign op_done   = (state_q == StDone);
  assign op_result = res_q;

endmodule

// File: tb/tb_m_ext_unit.sv
// Self-checking bench for m_ext_unit: directed corner cases, random operations
// against an arithmetic reference model, flush and mid-operation reset.
module tb_m_ext_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, flush;
  logic [2:0]   funct;
  logic [W-1:0] rs1, rs2;
  logic         busy, done;
  logic [W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  bit saw_done;

  always #5 clk = ~clk;

  m_ext_unit #(.WIDTH(W)) dut (
    .ip_clk      (clk),
    .ip_rst_n    (rst_n),
    .ip_start    (start),
    .ip_flush    (flush),
    .ip_funct_3  (funct),
    .ip_rs1_data (rs1),
    .ip_rs2_data (rs2),
    .op_busy     (busy),
    .op_done     (done),
    .op_result   (result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    p   = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hffff_ffff;
        if (ovf) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hffff_ffff;
        p = ua / ub;
        return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if (f[2] && !f[0] && (a == 32'h8000_0000) && (b == 32'hffff_ffff)) return 1;
    return W + 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
  endtask

  // Pulses start for one cycle; returns in the cycle after the accepting edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    funct = f;
    rs1   = a;
    rs2   = b;
    @(negedge clk);
    start = 1'b0;
    funct = 3'($urandom);
    rs1   = $urandom;
    rs2   = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] prior;
    int          lat;
    bit          stable;
    prior = result;
    issue(f, a, b);
    check({tag, " busy"}, 64'(busy), 64'(1));
    lat    = 0;
    stable = 1'b1;
    while (!done && lat < 100) begin
      if (result !== prior) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, 64'(result), 64'(exp));
    check({tag, " hold"}, 64'(stable), 64'(1));
    @(negedge clk);
    check({tag, " idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, a1, b1, prior;
    logic [2:0]  f;
    int          lat;

    rst_n = 1'b1; start = 1'b0; flush = 1'b0; funct = '0; rs1 = '0; rs2 = '0; saw_done = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset result", 64'(result), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op("mul", 3'd0, 32'd7, 32'hffff_fffd, 32'hffff_ffeb, 33);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhu", 3'd3, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 33);
    run_op("div ovf", 3'd4, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1);
    run_op("rem ovf", 3'd6, 32'h8000_0000, 32'hffff_ffff, 32'h0, 1);
    run_op("divu by0", 3'd5, 32'd5, 32'd0, 32'hffff_ffff, 1);
    run_op("remu by0", 3'd7, 32'd5, 32'd0, 32'd5, 1);
    run_op("div by0 neg", 3'd4, 32'hffff_fff9, 32'd0, 32'hffff_ffff, 1);
    run_op("rem by0 neg", 3'd6, 32'hffff_fff9, 32'd0, 32'hffff_fff9, 1);
    run_op("rem neg", 3'd6, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 33);
    run_op("div neg", 3'd4, 32'hffff_fff9, 32'd2, 32'hffff_fffd, 33);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hffff_ffff; end
        2: begin a = $urandom_range(0, 100); b = $urandom_range(1, 9); end
        3: b = -($urandom_range(1, 9));
        default: ;
      endcase
      run_op("random", f, a, b, ref_result(f, a, b), ref_lat(f, a, b));
    end

    // A start while busy must not disturb the operation in flight.
    a1 = $urandom;
    b1 = $urandom;
    issue(3'd1, a1, b1);
    tick(5);
    start = 1'b1; funct = 3'd5; rs1 = $urandom; rs2 = 32'h0;
    @(negedge clk);
    start = 1'b0;
    lat = 6;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("start ignored latency", 64'(lat), 64'(33));
    check("start ignored result", 64'(result), 64'(ref_result(3'd1, a1, b1)));

    // Flush at iteration 10 with a second start mid-way.
    @(negedge clk);
    prior    = result;
    saw_done = 1'b0;
    issue(3'd0, $urandom, $urandom);
    tick(4);
    start = 1'b1; funct = 3'd4; rs1 = $urandom; rs2 = $urandom;
    tick(1);
    start = 1'b0;
    tick(5);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'(0));
    check("flush result", 64'(result), 64'(prior));
    tick(40);
    check("flush no done", 64'(saw_done), 64'(0));
    check("flush result later", 64'(result), 64'(prior));

    // Flush in the completing cycle wins over completion.
    saw_done = 1'b0;
    issue(3'd3, $urandom, $urandom);
    tick(32);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(2);
    check("flush at end no done", 64'(saw_done), 64'(0));
    check("flush at end busy", 64'(busy), 64'(0));
    check("flush at end result", 64'(result), 64'(prior));

    // Flush beats a simultaneous start in idle.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush vs start busy", 64'(busy), 64'(0));
    run_op("after flush", 3'd0, 32'd9, 32'd9, 32'd81, 33);

    // Reset at iteration 20 discards the operation immediately.
    saw_done = 1'b0;
    issue(3'd2, $urandom, $urandom);
    tick(20);
    #2 rst_n = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'(0));
    check("midreset done", 64'(done), 64'(0));
    check("midreset result", 64'(result), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick(40);
    check("midreset no done", 64'(saw_done), 64'(0));
    run_op("mul after reset", 3'd0, 32'd3, 32'd4, 32'd12, 33);
    check("mul after reset value", 64'(result), 64'(12));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
